eu_mem_responder: RTL and testbench

- Responder end of the EU operand/result memory interface.
- Owns a DEPTH x 8-bit data store and serves one request at a time: operand reads (addr1/addr2 phases) and result write-back (addr3 phase) issued by the execution unit.
- Uses a valid/ready handshake on both the request and response channels, and clears the store after reset.

---
 rtl/eu_pkg.sv | 19 +
 rtl/eu_mem_array.sv | 40 ++++
 rtl/eu_mem_responder.sv | 156 +++++++++++++++
 tb/tb_eu_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eu_pkg.sv
// Shared definitions for the EU operand/result memory responder.
package eu_pkg;

   localparam int EU_DW    = 8;
   localparam int EU_AW    = 5;
   localparam int EU_DEPTH = 32;

   // Request direction, matching the EU's read_write encoding.
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // Responder FSM states.
   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/eu_mem_array.sv
// Single-port synchronous store with registered read.
// A write returns the written data on rdata (write-first).
// Addresses at or beyond DEPTH are never written and read back as zero.
module eu_mem_array #(
   parameter int DW    = 8,
   parameter int AW    = 5,
   parameter int DEPTH = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [DW-1:0] rdata_r;
   logic          in_range_s;

   assign in_range_s = ({1'b0, addr} < DEPTH_W);

   // Storage write and registered read; no reset on the array itself.
   always_ff @(posedge clk) begin
      if (in_range_s) begin
         if (we) begin
            mem_r[addr] <= wdata;
            rdata_r     <= wdata;
         end else begin
            rdata_r     <= mem_r[addr];
         end
      end else begin
         rdata_r <= {DW{1'b0}};
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/eu_mem_responder.sv
// Responder end of the EU operand/result memory interface.
// After reset the store is swept to zero, then one valid/ready request is
// served at a time, with the response presented one cycle after accept.
module eu_mem_responder
   import eu_pkg::*;
#(
   parameter int DW    = EU_DW,
   parameter int AW    = EU_AW,
   parameter int DEPTH = EU_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_rw,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          init_done
);

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_CLR = AW'(DEPTH - 1);

   state_t        state_r;
   state_t        state_next_s;
   logic [AW-1:0] clr_cnt_r;
   logic [AW-1:0] addr_hold_r;
   logic          req_ready_r;
   logic          rsp_valid_r;
   logic          rsp_err_r;
   logic          init_done_r;

   logic          mem_we_s;
   logic [AW-1:0] mem_addr_s;
   logic [DW-1:0] mem_wdata_s;
   logic [DW-1:0] mem_rdata_s;
   logic          in_range_s;
   logic          accept_s;
   logic          rsp_done_s;
   logic          last_clr_s;

   assign in_range_s = ({1'b0, req_addr} < DEPTH_W);
   assign last_clr_s = (clr_cnt_r == LAST_CLR);

   // Next-state and store-port control for the sweep/handshake FSM.
   always_comb begin
      state_next_s = state_r;
      mem_we_s     = 1'b0;
      mem_addr_s   = req_addr;
      mem_wdata_s  = req_wdata;
      accept_s     = 1'b0;
      rsp_done_s   = 1'b0;
      case (state_r)
         INIT: begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_r;
            mem_wdata_s = {DW{1'b0}};
            if (last_clr_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = INIT;
            end
         end
         IDLE: begin
            mem_addr_s = req_addr;
            if (req_valid && req_ready_r) begin
               accept_s     = 1'b1;
               mem_we_s     = (req_rw == RW_WRITE) && in_range_s;
               state_next_s = RESP;
            end else begin
               state_next_s = IDLE;
            end
         end
         RESP: begin
            // Keep re-reading the accepted word so the registered read stays stable.
            mem_addr_s = addr_hold_r;
            if (rsp_ready) begin
               rsp_done_s   = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: begin
            state_next_s = INIT;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= INIT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Clear-sweep address counter, restarted by every reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt_r <= {AW{1'b0}};
      end else if (state_r == INIT) begin
         clr_cnt_r <= clr_cnt_r + AW'(1);
      end else begin
         clr_cnt_r <= clr_cnt_r;
      end
   end

   // Handshake flags, error flag and captured address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         init_done_r <= 1'b0;
         addr_hold_r <= {AW{1'b0}};
      end else if (state_r == INIT && last_clr_s) begin
         req_ready_r <= 1'b1;
         init_done_r <= 1'b1;
      end else if (accept_s) begin
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b1;
         rsp_err_r   <= !in_range_s;
         addr_hold_r <= req_addr;
      end else if (rsp_done_s) begin
         rsp_valid_r <= 1'b0;
         req_ready_r <= 1'b1;
      end
   end

   eu_mem_array #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .addr  (mem_addr_s),
      .wdata (mem_wdata_s),
      .rdata (mem_rdata_s)
   );

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign init_done = init_done_r;
   // Read data is only exposed while a good response is pending, so it reads
   // zero out of reset and for out-of-range requests.
   assign rsp_rdata = (rsp_valid_r && !rsp_err_r) ? mem_rdata_s : {DW{1'b0}};

endmodule

// File: tb/tb_eu_mem_responder.sv
// Directed bench for eu_mem_responder: a DEPTH=32 instance for the main flow
// and a DEPTH=24 instance for out-of-range behaviour.
module tb_eu_mem_responder;
   import eu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       req_valid, req_ready, req_rw, rsp_valid, rsp_ready, rsp_err, init_done;
   logic [4:0] req_addr;
   logic [7:0] req_wdata, rsp_rdata;

   logic       req_valid_b, req_ready_b, req_rw_b, rsp_valid_b, rsp_ready_b, rsp_err_b, init_done_b;
   logic [4:0] req_addr_b;
   logic [7:0] req_wdata_b, rsp_rdata_b;

   int errors = 0;
   int checks = 0;

   logic       rv, er;
   logic [7:0] rd;
   int         n;

   eu_mem_responder #(.DW(8), .AW(5), .DEPTH(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .init_done(init_done)
   );

   eu_mem_responder #(.DW(8), .AW(5), .DEPTH(24)) u_dut24 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_rw(req_rw_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
      .rsp_err(rsp_err_b), .init_done(init_done_b)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction on the main instance; called at a negedge with req_ready=1, rsp_ready=1.
   task automatic xact(input logic rw, input logic [4:0] a, input logic [7:0] d,
                       output logic o_rv, output logic [7:0] o_rd, output logic o_er);
      req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
      @(negedge clk);
      o_rv = rsp_valid; o_rd = rsp_rdata; o_er = rsp_err;
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   // Same transaction on the DEPTH=24 instance.
   task automatic xact_b(input logic rw, input logic [4:0] a, input logic [7:0] d,
                         output logic o_rv, output logic [7:0] o_rd, output logic o_er);
      req_valid_b = 1'b1; req_rw_b = rw; req_addr_b = a; req_wdata_b = d;
      @(negedge clk);
      o_rv = rsp_valid_b; o_rd = rsp_rdata_b; o_er = rsp_err_b;
      req_valid_b = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b1; req_rw = RW_READ; req_addr = 5'd7; req_wdata = 8'h00; rsp_ready = 1'b1;
      req_valid_b = 1'b0; req_rw_b = RW_READ; req_addr_b = 5'd0; req_wdata_b = 8'h00; rsp_ready_b = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_init_done", init_done, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
      check("rst_rsp_err",   rsp_err,   1'b0);

      // INIT sweep length with a request already waiting.
      rst_n = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("init_len", n, 32);
      check("init_done_with_ready", init_done, 1'b1);

      // The held read of address 7 is accepted on the first IDLE edge.
      @(negedge clk);
      check("rd7_valid", rsp_valid, 1'b1);
      check("rd7_data",  rsp_rdata, 8'h00);
      check("rd7_err",   rsp_err,   1'b0);
      check("rd7_ready_low", req_ready, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      check("rd7_done_valid", rsp_valid, 1'b0);
      check("rd7_done_ready", req_ready, 1'b1);

      // Write 0xA5 to addr 3 then read it back, read held during the response.
      req_valid = 1'b1; req_rw = RW_WRITE; req_addr = 5'd3; req_wdata = 8'hA5;
      @(negedge clk);
      check("wr3_valid", rsp_valid, 1'b1);
      check("wr3_echo",  rsp_rdata, 8'hA5);
      check("wr3_ready_low", req_ready, 1'b0);
      req_rw = RW_READ; req_wdata = 8'h00;
      @(negedge clk);
      check("wr3_done_valid", rsp_valid, 1'b0);
      check("wr3_done_ready", req_ready, 1'b1);
      @(negedge clk);
      check("rd3_valid", rsp_valid, 1'b1);
      check("rd3_data",  rsp_rdata, 8'hA5);
      req_valid = 1'b0;
      @(negedge clk);
      check("rd3_done_valid", rsp_valid, 1'b0);

      // EU sequence.
      xact(RW_WRITE, 5'd1, 8'h12, rv, rd, er);
      check("eu_wr1_echo", rd, 8'h12);
      xact(RW_WRITE, 5'd2, 8'h34, rv, rd, er);
      check("eu_wr2_echo", rd, 8'h34);
      xact(RW_READ, 5'd1, 8'h00, rv, rd, er);
      check("eu_rd1_valid", rv, 1'b1);
      check("eu_rd1_data", rd, 8'h12);
      xact(RW_READ, 5'd2, 8'h00, rv, rd, er);
      check("eu_rd2_data", rd, 8'h34);
      xact(RW_WRITE, 5'd5, 8'h46, rv, rd, er);
      check("eu_wr5_err", er, 1'b0);
      xact(RW_READ, 5'd5, 8'h00, rv, rd, er);
      check("eu_rd5_data", rd, 8'h46);

      // Backpressure: response held, second request waits.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_rw = RW_READ; req_addr = 5'd3;
      @(negedge clk);
      check("bp_first_valid", rsp_valid, 1'b1);
      req_addr = 5'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", rsp_valid, 1'b1);
         check("bp_hold_data",  rsp_rdata, 8'hA5);
         check("bp_hold_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", rsp_valid, 1'b0);
      check("bp_release_ready", req_ready, 1'b1);
      @(negedge clk);
      check("bp_second_valid", rsp_valid, 1'b1);
      check("bp_second_data",  rsp_rdata, 8'h12);
      req_valid = 1'b0;
      @(negedge clk);
      check("bp_second_done", rsp_valid, 1'b0);

      // DEPTH=24 instance: out-of-range accesses.
      check("d24_init_done", init_done_b, 1'b1);
      check("d24_ready", req_ready_b, 1'b1);
      xact_b(RW_WRITE, 5'd30, 8'hFF, rv, rd, er);
      check("d24_wr30_valid", rv, 1'b1);
      check("d24_wr30_err", er, 1'b1);
      check("d24_wr30_data", rd, 8'h00);
      xact_b(RW_READ, 5'd30, 8'h00, rv, rd, er);
      check("d24_rd30_err", er, 1'b1);
      check("d24_rd30_data", rd, 8'h00);
      xact_b(RW_READ, 5'd6, 8'h00, rv, rd, er);
      check("d24_rd6_data", rd, 8'h00);
      check("d24_rd6_err", er, 1'b0);
      xact_b(RW_READ, 5'd14, 8'h00, rv, rd, er);
      check("d24_rd14_data", rd, 8'h00);
      xact_b(RW_READ, 5'd23, 8'h00, rv, rd, er);
      check("d24_rd23_data", rd, 8'h00);
      check("d24_rd23_err", er, 1'b0);

      // Reset while a response holding 0xA5 is pending.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_rw = RW_READ; req_addr = 5'd3;
      @(negedge clk);
      check("mid_valid", rsp_valid, 1'b1);
      check("mid_data",  rsp_rdata, 8'hA5);
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid, 1'b0);
      check("mid_rst_data",  rsp_rdata, 8'h00);
      check("mid_rst_init_done", init_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reinit_len", n, 32);
      xact(RW_READ, 5'd3, 8'h00, rv, rd, er);
      check("reinit_rd3_valid", rv, 1'b1);
      check("reinit_rd3_data", rd, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
